// File: rtl/line_buff_ctrl_pkg.sv
// Shared types, default VGA/tile timing and helpers for the ping-pong line buffer controller.
package vga_lbuff_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int DEF_WIDTH_PX   = 640;
    localparam int DEF_HEIGHT_PX  = 480;
    localparam int DEF_H_TOTAL    = 800;
    localparam int DEF_V_TOTAL    = 525;
    localparam int DEF_TILE_WIDTH = 4;
    localparam int DEF_LEAD_PX    = 2;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/line_buff_ctrl_if.sv
// Controller <-> line buffer pair signals: fill handshake, display select and read id.
interface line_buff_ctrl_if
    import vga_lbuff_pkg::*;
#(
    parameter int TILE_CTR_WIDTH = $clog2(DEF_WIDTH_PX / DEF_TILE_WIDTH),
    parameter int TROW_W         = $clog2(DEF_HEIGHT_PX / DEF_TILE_WIDTH)
);
    logic [1:0]                buff_fill_req_o;
    logic [1:0]                buff_fill_done_i;
    logic [1:0]                buff_sel_o;
    logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o;
    logic [TROW_W-1:0]         fill_tile_row_o;

    modport master (
        output buff_fill_req_o,
        output buff_sel_o,
        output disp_pxl_id_o,
        output fill_tile_row_o,
        input  buff_fill_done_i
    );

    modport slave (
        input  buff_fill_req_o,
        input  buff_sel_o,
        input  disp_pxl_id_o,
        input  fill_tile_row_o,
        output buff_fill_done_i
    );
endinterface

// File: rtl/line_buff_ctrl.sv
// Ping-pong line buffer controller: schedules tile-row fills one row ahead of display,
// selects the display buffer per tile row, generates the read tile id and flags late fills.
module line_buff_ctrl
    import vga_lbuff_pkg::*;
#(
    parameter int  WIDTH_PX       = DEF_WIDTH_PX,
    parameter int  HEIGHT_PX      = DEF_HEIGHT_PX,
    parameter int  H_TOTAL        = DEF_H_TOTAL,
    parameter int  V_TOTAL        = DEF_V_TOTAL,
    parameter int  TILE_WIDTH     = DEF_TILE_WIDTH,
    parameter int  LEAD_PX        = DEF_LEAD_PX,
    localparam int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
    localparam int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
    localparam int TROWS          = HEIGHT_PX / TILE_WIDTH,
    localparam int TROW_W         = $clog2(TROWS),
    localparam int PXL_CTR_W      = $clog2(H_TOTAL),
    localparam int LN_CTR_W       = $clog2(V_TOTAL)
)(
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 en_i,
    input  logic [PXL_CTR_W-1:0] pxl_x_i,
    input  logic [LN_CTR_W-1:0]  pxl_y_i,
    line_buff_ctrl_if.master     bus,
    output logic                 underrun_o
);

    localparam int TW_SH = $clog2(TILE_WIDTH);

    fill_state_t               state_q, state_d;
    logic                      tgt_q, tgt_d;
    logic [TROW_W-1:0]         row_q, row_d;
    logic                      pre_q, pre_d;
    logic                      primed_q, primed_d;
    logic [1:0]                req_q, req_d;
    logic [1:0]                sel_q, sel_d;
    logic                      underrun_q, underrun_d;
    logic [TILE_CTR_WIDTH-1:0] id_q, id_d;

    logic                line_end, y_active, row_start;
    logic                prefetch, advance, trigger, done_hit;
    logic [LN_CTR_W-1:0] next_y, nrow_full;
    logic [TROW_W-1:0]   nrow, adv_row, trig_row;
    logic                trig_buf;
    logic [PXL_CTR_W:0]  s_raw, s_wrap;

    // Line-end decode: everything below looks at the line that starts next.
    assign line_end  = (pxl_x_i == PXL_CTR_W'(H_TOTAL - 1));
    assign next_y    = (pxl_y_i == LN_CTR_W'(V_TOTAL - 1)) ? '0 : pxl_y_i + 1'b1;
    assign nrow_full = next_y >> TW_SH;
    assign nrow      = nrow_full[TROW_W-1:0];
    assign y_active  = (next_y < LN_CTR_W'(HEIGHT_PX));
    assign row_start = ((next_y & LN_CTR_W'(TILE_WIDTH - 1)) == '0);

    assign prefetch = en_i && line_end && (pxl_y_i == LN_CTR_W'(HEIGHT_PX));
    assign advance  = en_i && line_end && y_active && row_start && primed_q
                      && (nrow_full < LN_CTR_W'(TROWS - 1));
    assign trigger  = prefetch || advance;

    // Row nrow+1 goes to the buffer not being displayed.
    assign adv_row  = nrow + 1'b1;
    assign trig_buf = prefetch ? 1'b0 : adv_row[0];
    assign trig_row = prefetch ? '0 : adv_row;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        row_d      = row_q;
        pre_d      = pre_q;
        primed_d   = primed_q;
        sel_d      = sel_q;
        underrun_d = underrun_q;
        done_hit   = 1'b0;

        if (line_end) begin
            if (y_active && primed_q) begin
                sel_d = onehot2(nrow[0]);
                if ((req_q & sel_d) != 2'b00)
                    underrun_d = 1'b1;
            end else begin
                sel_d = 2'b00;
            end
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = FILL;
                    tgt_d   = trig_buf;
                    row_d   = trig_row;
                    pre_d   = prefetch;
                end
            end
            FILL: begin
                done_hit = bus.buff_fill_done_i[tgt_q];
                if (done_hit) begin
                    state_d = IDLE;
                    if (pre_q)
                        primed_d = 1'b1;
                end
                // A completing fill frees the slot for a same-cycle trigger.
                if (trigger) begin
                    if (done_hit) begin
                        state_d = FILL;
                        tgt_d   = trig_buf;
                        row_d   = trig_row;
                        pre_d   = prefetch;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en_i) begin
            state_d    = IDLE;
            primed_d   = 1'b0;
            sel_d      = 2'b00;
            underrun_d = 1'b0;
        end

        req_d = (state_d == FILL) ? onehot2(tgt_d) : 2'b00;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            row_q      <= '0;
            pre_q      <= 1'b0;
            primed_q   <= 1'b0;
            req_q      <= 2'b00;
            sel_q      <= 2'b00;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            row_q      <= row_d;
            pre_q      <= pre_d;
            primed_q   <= primed_d;
            req_q      <= req_d;
            sel_q      <= sel_d;
            underrun_q <= underrun_d;
        end
    end

    // Read id runs LEAD_PX ahead to cover the output register and RAM read latency.
    assign s_raw  = {1'b0, pxl_x_i} + (PXL_CTR_W + 1)'(LEAD_PX);
    assign s_wrap = (s_raw >= (PXL_CTR_W + 1)'(H_TOTAL)) ? s_raw - (PXL_CTR_W + 1)'(H_TOTAL) : s_raw;
    assign id_d   = (s_wrap < (PXL_CTR_W + 1)'(WIDTH_PX)) ? TILE_CTR_WIDTH'(s_wrap >> TW_SH)
                                                          : TILE_CTR_WIDTH'(TILE_PER_LINE - 1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            id_q <= '0;
        else
            id_q <= id_d;
    end

    assign bus.buff_fill_req_o = req_q;
    assign bus.buff_sel_o      = sel_q;
    assign bus.disp_pxl_id_o   = id_q;
    assign bus.fill_tile_row_o = row_q;
    assign underrun_o          = underrun_q;

endmodule

// File: tb/tb_line_buff_ctrl.sv
// Bench for line_buff_ctrl: sparse-x VGA counters, a done responder and a rule-level model.
module tb_line_buff_ctrl;
    import vga_lbuff_pkg::*;

    localparam int W = 640, H = 480, HT = 800, VT = 525, TW = 4, LEAD = 2;
    localparam int TPL = 160, TROWS = 120, LAT = 25;

    logic       clk = 1'b0;
    logic       rstn, en, underrun;
    logic [9:0] x, y;

    line_buff_ctrl_if #(.TILE_CTR_WIDTH(8), .TROW_W(7)) bus();

    line_buff_ctrl dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .en_i      (en),
        .pxl_x_i   (x),
        .pxl_y_i   (y),
        .bus       (bus),
        .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    // Model: outstanding fill (buffer/row or none), primed flag, sticky underrun, select, id.
    int m_buf = -1, m_row = 0, m_req_id = 0, m_sel = 0, m_id = 0;
    bit m_pre = 1'b0, m_primed = 1'b0, m_under = 1'b0;

    function automatic int exp_req();
        return (m_buf < 0) ? 0 : (1 << m_buf);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)", nm, act, exp, x, y, $time);
        end
    endtask

    task automatic model_step(input int px, input int py, input bit pen, input bit [1:0] pdone);
        int  ny, nr, s;
        bit  le, pre, adv, busy, fin;
        s    = (px + LEAD) % HT;
        m_id = (s < W) ? s / TW : TPL - 1;
        if (!pen) begin
            m_buf = -1; m_sel = 0; m_under = 1'b0; m_primed = 1'b0;
            return;
        end
        ny   = (py + 1) % VT;
        nr   = ny / TW;
        le   = (px == HT - 1);
        pre  = le && (py == H);
        adv  = le && (ny < H) && (ny % TW == 0) && (nr < TROWS - 1) && m_primed;
        busy = (m_buf >= 0);
        fin  = busy && pdone[m_buf];
        if (le) begin
            if (ny < H && m_primed) begin
                m_sel = 1 << (nr % 2);
                if (busy && m_buf == nr % 2) m_under = 1'b1;
            end else begin
                m_sel = 0;
            end
        end
        if (fin) begin
            if (m_pre) m_primed = 1'b1;
            m_buf = -1;
        end
        if (pre || adv) begin
            if (busy && !fin) m_under = 1'b1;
            else begin
                m_buf = pre ? 0 : (nr + 1) % 2;
                m_row = pre ? 0 : nr + 1;
                m_pre = pre;
                m_req_id++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req", {30'd0, bus.buff_fill_req_o}, exp_req());
            chk("sel", {30'd0, bus.buff_sel_o}, m_sel);
            chk("id", {24'd0, bus.disp_pxl_id_o}, m_id);
            chk("underrun", {31'd0, underrun}, {31'd0, m_under});
            if (m_buf >= 0) chk("row", {25'd0, bus.fill_tile_row_o}, m_row);
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        $display("point %s got %0d want %0d", nm, act, exp);
        chk(nm, act, exp);
    endtask

    initial begin
        int  cx, cy, fr, sx, sy, sfr, seen_id, cnt;
        bit  sen, full, hold1, done_flag;
        bit [1:0] sdone, d;
        cx = 0; cy = 0; fr = 0; seen_id = 0; cnt = 0;
        rstn = 1'b0; en = 1'b0; x = '0; y = '0;
        bus.buff_fill_done_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        lit("rst_req", {30'd0, bus.buff_fill_req_o}, 0);
        lit("rst_sel", {30'd0, bus.buff_sel_o}, 0);
        lit("rst_id", {24'd0, bus.disp_pxl_id_o}, 0);
        lit("rst_row", {25'd0, bus.fill_tile_row_o}, 0);
        lit("rst_underrun", {31'd0, underrun}, 0);
        rstn = 1'b1; en = 1'b1;
        chk_on = 1'b1;
        done_flag = 1'b0;

        while (!done_flag) begin
            @(posedge clk);
            sx = cx; sy = cy; sfr = fr; sen = en; sdone = bus.buff_fill_done_i;
            model_step(sx, sy, sen, sdone);
            #1;

            if (sfr == 0 && sy == 0) begin
                case (sx)
                    0:   lit("id_x0", {24'd0, bus.disp_pxl_id_o}, 0);
                    637: lit("id_x637", {24'd0, bus.disp_pxl_id_o}, 159);
                    638: lit("id_x638", {24'd0, bus.disp_pxl_id_o}, 159);
                    797: lit("id_x797", {24'd0, bus.disp_pxl_id_o}, 159);
                    798: lit("id_x798", {24'd0, bus.disp_pxl_id_o}, 0);
                    799: begin
                        lit("id_x799", {24'd0, bus.disp_pxl_id_o}, 0);
                        lit("idle_req", {30'd0, bus.buff_fill_req_o}, 0);
                        lit("idle_sel", {30'd0, bus.buff_sel_o}, 0);
                    end
                    default: ;
                endcase
            end
            if (sx == 798 && sfr == 0 && sy == 480) lit("pre_early", {30'd0, bus.buff_fill_req_o}, 0);
            if (sx == 799) begin
                if (sfr == 0 && sy == 480) begin
                    lit("pre_req", {30'd0, bus.buff_fill_req_o}, 1);
                    lit("pre_row", {25'd0, bus.fill_tile_row_o}, 0);
                end
                if (sfr == 0 && sy == 524) begin
                    lit("first_sel", {30'd0, bus.buff_sel_o}, 1);
                    lit("row1_req", {30'd0, bus.buff_fill_req_o}, 2);
                    lit("row1_row", {25'd0, bus.fill_tile_row_o}, 1);
                end
                if (sfr == 1 && sy == 3) begin
                    lit("y3_sel", {30'd0, bus.buff_sel_o}, 2);
                    lit("y3_req", {30'd0, bus.buff_fill_req_o}, 1);
                    lit("y3_row", {25'd0, bus.fill_tile_row_o}, 2);
                end
                if (sfr == 1 && sy == 7) lit("y7_sel", {30'd0, bus.buff_sel_o}, 1);
                if (sfr == 1 && sy == 471) begin
                    lit("r119_req", {30'd0, bus.buff_fill_req_o}, 2);
                    lit("r119_row", {25'd0, bus.fill_tile_row_o}, 119);
                end
                if (sfr == 1 && sy == 475) lit("no_r120", {30'd0, bus.buff_fill_req_o}, 0);
                if (sfr == 1 && sy == 479) begin
                    lit("y479_sel", {30'd0, bus.buff_sel_o}, 0);
                    lit("frame_no_underrun", {31'd0, underrun}, 0);
                end
                if (sfr == 2 && sy == 3) begin
                    lit("late_underrun", {31'd0, underrun}, 1);
                    lit("late_req", {30'd0, bus.buff_fill_req_o}, 2);
                end
                if (sfr == 2 && sy == 100) begin
                    lit("wait_req", {30'd0, bus.buff_fill_req_o}, 0);
                    lit("wait_sel", {30'd0, bus.buff_sel_o}, 0);
                end
                if (sfr == 3 && sy == 3) begin
                    lit("swap_req", {30'd0, bus.buff_fill_req_o}, 1);
                    lit("swap_row", {25'd0, bus.fill_tile_row_o}, 2);
                end
            end
            if (sfr == 2 && sy == 9 && sx == 3) begin
                lit("clr_underrun", {31'd0, underrun}, 0);
                lit("clr_sel", {30'd0, bus.buff_sel_o}, 0);
                lit("clr_req", {30'd0, bus.buff_fill_req_o}, 0);
            end

            // Advance counters; only one full line, the rest skip the middle of the line.
            full = (fr == 0 && cy == 0);
            if (cx == HT - 1) begin
                cx = 0;
                if (cy == VT - 1) begin cy = 0; fr++; end
                else cy++;
            end else if (!full && cx == 5) cx = 634;
            else if (!full && cx == 643) cx = 794;
            else cx++;
            if (fr == 3 && cy == 12) done_flag = 1'b1;

            x  = cx[9:0];
            y  = cy[9:0];
            en = !(fr == 2 && cy == 9 && cx == 3);

            hold1 = (fr == 1 && cy >= 520) || (fr == 2 && cy <= 9) ||
                    (fr == 2 && cy >= 520) || (fr == 3 && cy <= 3);
            d = 2'b00;
            if (m_buf >= 0) begin
                if (m_req_id != seen_id) begin seen_id = m_req_id; cnt = LAT; end
                if (!(hold1 && m_buf == 1)) begin
                    if (cnt == 0) d = (m_buf == 1) ? 2'b10 : 2'b01;
                    else cnt--;
                end
            end
            if (fr == 2 && cy == 9 && cx == 5) d = 2'b10;
            if (fr == 3 && cy == 3 && cx == 799) d = 2'b10;
            bus.buff_fill_done_i = d;
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
